// File: rtl/freq_div_pkg.sv
// Shared types and constants for the freq_div_sched clock-divider controller.
package freq_div_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DIV_STOP  = 0;

  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_e;
endpackage

// File: rtl/freq_div_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module freq_div_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);
  // ptr_q=1 gives requester 1 priority on a tie
  logic       ptr_q, ptr_d;
  logic [1:0] win;

  assign win[0] = req_i[0] & (~req_i[1] | ~ptr_q);
  assign win[1] = req_i[1] & (~req_i[0] |  ptr_q);
  assign gnt_o  = en_i ? win : 2'b00;
  assign ptr_d  = upd_i ? gnt_o[0] : ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/freq_div_sched.sv
// 50%-duty programmable divider with arbitrated, glitch-free ratio updates.
// Optional FREQ_DIV_SCHED_APPLY_NOW_EN adds apply_now to force an early apply.
module freq_div_sched
  import freq_div_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = 5
) (
  input  logic             clockin,
  input  logic             reset,
`ifdef FREQ_DIV_SCHED_APPLY_NOW_EN
  input  logic             apply_now,
`endif
  input  logic             req0,
  input  logic [WIDTH-1:0] div0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] div1,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cur_div,
  output logic             tick,
  output logic             clockout
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d;
  logic             clk_q, clk_d;
  logic [1:0]       gnt;
  logic             xfer, running, at_fall, force_apply, apply;

  freq_div_rr_arb u_arb (
    .clk_i (clockin),
    .rst_i (reset),
    .req_i ({req1, req0}),
    .en_i  (state_q == IDLE),
    .upd_i (xfer),
    .gnt_o (gnt)
  );

`ifdef FREQ_DIV_SCHED_APPLY_NOW_EN
  assign force_apply = apply_now;
`else
  assign force_apply = 1'b0;
`endif

  assign xfer    = |gnt;
  assign running = (cur_q != WIDTH'(DIV_STOP));
  // a falling clockout edge is the only safe point to change the period
  assign at_fall = running & (cnt_q == '0) & clk_q;
  assign apply   = (state_q == PEND) & (~running | at_fall | force_apply);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    tick    = 1'b0;
    case (state_q)
      IDLE:    if (xfer) begin
                 state_d = PEND;
                 pend_d  = gnt[0] ? div0 : div1;
               end
      PEND:    if (apply) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (apply) begin
      cur_d = pend_q;
      clk_d = 1'b0;
      tick  = clk_q;
      cnt_d = (pend_q == WIDTH'(DIV_STOP)) ? '0 : pend_q - 1'b1;
    end else if (running) begin
      if (cnt_q == '0) begin
        cnt_d = cur_q - 1'b1;
        clk_d = ~clk_q;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else begin
      cnt_d = '0;
      clk_d = 1'b0;
    end
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= WIDTH'(RESET_DIV);
      pend_q  <= '0;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
    end
  end

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign busy     = (state_q == PEND);
  assign done     = (state_q == APPLY);
  assign cur_div  = cur_q;
  assign clockout = clk_q;
endmodule

// File: doc/freq_div_sched.md
Name: freq_div_sched

Overview:
- Runtime controller for a programmable 50%-duty clock divider. The divide engine is integrated: it produces clockout with period 2*cur_div input cycles.
- Two requesters share the divider's ratio setting through a round-robin arbiter.
- An accepted ratio is held pending. It is applied only at a full-period boundary, so clockout never produces a runt pulse.
- Sits between software/sequencer requesters and clock-enable consumers in the clock-generation area.

Parameters:
- WIDTH, 8, width of divisor values and the internal counter.
- RESET_DIV, 5, divisor loaded at reset (clockout = clockin/10).

Ports:
- clockin  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 asks to load div0.
- div0  in  WIDTH  requested divisor from requester 0; 0 means stop.
- gnt0  out  1  requester 0's request is accepted this cycle.
- req1  in  1  requester 1 asks to load div1.
- div1  in  WIDTH  requested divisor from requester 1.
- gnt1  out  1  requester 1's request is accepted this cycle.
- busy  out  1  a pending ratio is waiting to be applied.
- done  out  1  one-cycle pulse the cycle after a pending ratio is applied.
- cur_div  out  WIDTH  divisor currently in effect.
- tick  out  1  one-cycle pulse at every clockout edge.
- clockout  out  1  divided clock.

Behaviour:
- Reset (synchronous, active-high; all values registered on clockin):
  - clockout=0, counter=0, cur_div=RESET_DIV, pending cleared, busy=0, done=0, rr pointer favours req0.
  - Reset mid-operation discards any pending ratio; no done is issued.
- Divide engine, running (cur_div!=0):
  - When counter==0: counter<=cur_div-1, clockout toggles, tick=1.
  - Otherwise counter decrements.
  - First toggle occurs in the first cycle after reset. High and low phases are each cur_div cycles.
- Stopped (cur_div==0): counter held at 0, clockout held 0, tick=0.
- Handshake:
  - gnt_i is combinational: gnt_i = req_i & ~busy & arbiter-win.
  - A transfer occurs on a cycle with req_i & gnt_i; div_i is captured into the pending register then.
  - A requester holds req_i and div_i stable until granted, and drops req_i the cycle after the grant.
- Arbitration: if both requesters ask, grant the one not granted last. The rr pointer updates only on a transfer.
- FSM states:
  - IDLE: nothing pending. A transfer moves to PEND.
  - PEND: busy=1, no grants. Transitions to APPLY at the boundary defined below.
  - APPLY: one cycle. done=1, then back to IDLE.
- Apply boundary in PEND:
  - Running: boundary is a cycle with counter==0 & clockout==1, i.e. the falling edge of clockout. That cycle: cur_div<=pending, clockout<=0, counter<=pending-1, tick=1.
  - Stopped: boundary is the first cycle in PEND.
- Boundary conditions:
  - Pending value 0: clockout falls and the engine stops.
  - Pending value equal to cur_div: still a full handshake with done; no waveform change.
  - Value 1: clockout toggles every cycle (clockin/2).
- Simultaneous events:
  - Transfer in the same cycle as a falling boundary: not applied at that boundary; waits for the next one.
  - Request arriving during APPLY: not granted; busy is 0 in APPLY but the FSM is not in IDLE, so gnt is also gated by state==IDLE.
- Arithmetic: divisor values are unsigned WIDTH bits. pending-1 is never computed for 0.

Optional Feature:
- Macro FREQ_DIV_SCHED_APPLY_NOW_EN.
- Defined:
  - Adds input port apply_now (1 bit).
  - apply_now=1 in PEND forces the apply boundary in that cycle regardless of counter or clockout. clockout<=0 and the counter reloads.
  - Accepts a possible short final phase.
- Undefined: port absent; apply happens only at natural boundaries.

Decomposition:
- Package freq_div_pkg holds:
  - state enum {IDLE, PEND, APPLY};
  - localparam DIV_STOP = 0;
  - the default WIDTH constant.
- One sub-module, freq_div_rr_arb: 2-way round-robin arbiter with inputs req[1:0], enable and update, and output gnt[1:0] plus pointer state.
- Divide engine and FSM stay in the top.

Test Plan:
- Reset release, no requests:
  - First clockout rise in cycle 1, then 5 high / 5 low repeating.
  - tick every 5 cycles, cur_div=5.
- req0 with div0=3 in cycle 2, during the high phase:
  - gnt0 in cycle 2, busy from cycle 3.
  - Apply at the falling edge in cycle 5, done in cycle 6.
  - Thereafter clockout is 3 high / 3 low.
- req0 and req1 asserted together (div0=2, div1=4):
  - gnt0 first; req1 is held off while busy and granted in the cycle after done.
  - cur_div goes 2 then 4.
  - On the next simultaneous pair, req1 wins.
- div0=0 applied:
  - clockout falls at the boundary and stays 0; tick stops.
  - A subsequent div1=2 applies in the cycle after the grant, with done one cycle later.
  - clockout then resumes with period 4.
- Transfer in the same cycle as a falling boundary: pending applies one full period later, not immediately.
- reset asserted while busy: next cycle busy=0, cur_div=5, clockout=0, no done pulse. With FREQ_DIV_SCHED_APPLY_NOW_EN, apply_now in PEND gives done on the following cycle.
